// File: rtl/poly_voice_if.sv
// -----------------------------------------------------------------------------
// poly_voice_if
//
// Bus between the keypad/octave logic and the polyphonic tone engine.
//   master : drives per-voice phase increments, key gates, waveform mode and
//            the one-cycle sample request; observes the mixer and PWM outputs.
//   slave  : the engine side.
//
// Signals:
//   inc_flat     VOICES*ACC_W  phase increment of voice i at [i*ACC_W +: ACC_W]
//   key_en       VOICES        gate per voice (1 = held)
//   mode         2             00 square, 01 saw, 10 triangle, 11 25% pulse
//   sample_tick  1             one-cycle sample request
//   sample_out   SAMPLE_W      last mixed sample
//   sample_valid 1             one-cycle pulse when sample_out updates
//   clipped      1             saturation flag belonging to sample_out
//   busy         1             mix in progress
//   overrun      1             sticky: tick arrived while busy
//   pwm_out      1             registered PWM output
// -----------------------------------------------------------------------------
interface poly_voice_if #(
    parameter int VOICES   = 12,
    parameter int ACC_W    = 18,
    parameter int SAMPLE_W = 8
);
    logic [VOICES*ACC_W-1:0] inc_flat;
    logic [VOICES-1:0]       key_en;
    logic [1:0]              mode;
    logic                    sample_tick;
    logic [SAMPLE_W-1:0]     sample_out;
    logic                    sample_valid;
    logic                    clipped;
    logic                    busy;
    logic                    overrun;
    logic                    pwm_out;

    modport master (
        output inc_flat, key_en, mode, sample_tick,
        input  sample_out, sample_valid, clipped, busy, overrun, pwm_out
    );

    modport slave (
        input  inc_flat, key_en, mode, sample_tick,
        output sample_out, sample_valid, clipped, busy, overrun, pwm_out
    );
endinterface

// File: rtl/poly_voice_engine.sv
// -----------------------------------------------------------------------------
// poly_voice_engine
//
// Polyphonic tone engine: VOICES free-running phase accumulators, a shared
// waveshaper, per-voice linear attack/release envelopes, a time-multiplexed
// saturating mixer (one voice per clock) and a PWM DAC.
//
// Ports:
//   clk    system clock
//   n_rst  synchronous reset, active HIGH despite the name
//   bus    poly_voice_if.slave (increments, gates, mode, tick in;
//          sample, flags and pwm_out out)
// -----------------------------------------------------------------------------
module poly_voice_engine #(
    parameter int VOICES     = 12,
    parameter int ACC_W      = 18,
    parameter int SAMPLE_W   = 8,
    parameter int GAIN_SHIFT = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    poly_voice_if.slave bus
);
    localparam int MIX_W = SAMPLE_W + $clog2(VOICES + 1);
    localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [SAMPLE_W-1:0] FS       = '1;
    localparam logic [4:0]          AMP_MAX  = 5'd16;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(VOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;
    typedef enum logic [1:0] {W_SQUARE = 2'b00, W_SAW = 2'b01,
                              W_TRI = 2'b10, W_PULSE = 2'b11} wave_t;

    logic [ACC_W-1:0]    phase [VOICES];
    logic [4:0]          amp   [VOICES];
    state_t              state, state_nxt;
    wave_t               mode_q;
    logic [IDX_W-1:0]    idx;
    logic [MIX_W-1:0]    acc;
    logic [SAMPLE_W-1:0] sample_q, duty, pwm_cnt;
    logic                valid_q, clip_q, overrun_q, pwm_q;

    // ---------------- oscillators: run every clock, gate or not -------------
    always_ff @(posedge clk) begin
        // NOTE: phase/amp are individual flops with defined reset values, not a
        // RAM, so they are cleared element by element here.
        if (n_rst) begin
            for (int i = 0; i < VOICES; i++) phase[i] <= '0;
        end else begin
            // NOTE: all sequential state uses non-blocking assignment so every
            // register samples the pre-edge value of every other register.
            for (int i = 0; i < VOICES; i++)
                phase[i] <= phase[i] + bus.inc_flat[i*ACC_W +: ACC_W];
        end
    end

    // ---------------- waveshaper + envelope scaling for voice idx -----------
    logic [SAMPLE_W-1:0] t, u, wave, contrib;
    logic [SAMPLE_W+4:0] prod;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        wave = '0;
        t    = SAMPLE_W'(phase[idx] >> (ACC_W - SAMPLE_W));
        u    = {t[SAMPLE_W-2:0], 1'b0};
        case (mode_q)
            W_SQUARE: wave = t[SAMPLE_W-1] ? '0 : FS;
            W_SAW:    wave = t;
            W_TRI:    wave = t[SAMPLE_W-1] ? ~u : u;
            W_PULSE:  wave = (t[SAMPLE_W-1 -: 2] == 2'b00) ? FS : '0;
            default:  wave = '0;
        endcase
        // amp is 0..16, so >>4 makes amp 16 a unity gain
        prod    = {5'b0, wave} * {{SAMPLE_W{1'b0}}, amp[idx]};
        contrib = SAMPLE_W'(prod >> 4);
    end

    // ---------------- gain and saturation of the finished sum ---------------
    logic [MIX_W-1:0]    mixed;
    logic                mix_clip;
    logic [SAMPLE_W-1:0] mix_sat;

    always_comb begin
        mixed    = acc >> GAIN_SHIFT;
        mix_clip = (mixed > MIX_W'(FS));
        mix_sat  = mix_clip ? FS : mixed[SAMPLE_W-1:0];
    end

    // ---------------- mixer FSM ---------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.sample_tick) state_nxt = S_ACCUM;
            S_ACCUM: if (idx == LAST_IDX) state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state     <= S_IDLE;
            mode_q    <= W_SQUARE;
            idx       <= '0;
            acc       <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            clip_q    <= 1'b0;
            overrun_q <= 1'b0;
            duty      <= '0;
            for (int i = 0; i < VOICES; i++) amp[i] <= '0;
        end else begin
            state   <= state_nxt;
            valid_q <= 1'b0;
            // ticks during ACCUM or OUT are dropped; only the flag remembers them
            if (bus.sample_tick && state != S_IDLE) overrun_q <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.sample_tick) begin
                        mode_q <= wave_t'(bus.mode);
                        idx    <= '0;
                        acc    <= '0;
                        for (int i = 0; i < VOICES; i++) begin
                            if (bus.key_en[i] && amp[i] < AMP_MAX)
                                amp[i] <= amp[i] + 5'd1;
                            else if (!bus.key_en[i] && amp[i] != 5'd0)
                                amp[i] <= amp[i] - 5'd1;
                        end
                    end
                end
                S_ACCUM: begin
                    acc <= acc + MIX_W'(contrib);
                    idx <= idx + IDX_W'(1);
                end
                S_OUT: begin
                    sample_q <= mix_sat;
                    clip_q   <= mix_clip;
                    valid_q  <= 1'b1;
                    duty     <= mix_sat;
                end
                default: ;
            endcase
        end
    end

    // ---------------- PWM DAC -----------------------------------------------
    always_ff @(posedge clk) begin
        if (n_rst) begin
            pwm_cnt <= '0;
            pwm_q   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + SAMPLE_W'(1);
            pwm_q   <= (pwm_cnt < duty);
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.clipped      = clip_q;
    assign bus.busy         = (state != S_IDLE);
    assign bus.overrun      = overrun_q;
    assign bus.pwm_out      = pwm_q;
endmodule
